// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: widths, size codes,
// FSM states, the captured-request payload and the size-to-lane helper.
package lsu_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned ADDR_WIDTH = 10;
    localparam int unsigned MASK_WIDTH = DATA_WIDTH >> 3;
    localparam int unsigned WORD_WIDTH = ADDR_WIDTH - 3;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic                  we;
        size_e                 size;
        logic                  is_unsigned;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    // Byte lanes touched by an access of the given size, LSB-justified.
    function automatic logic [MASK_WIDTH-1:0] size_lanes(input size_e size);
        logic [MASK_WIDTH-1:0] lanes;
        case (size)
            SZ_B:    lanes = MASK_WIDTH'(8'h01);
            SZ_H:    lanes = MASK_WIDTH'(8'h03);
            SZ_W:    lanes = MASK_WIDTH'(8'h0F);
            default: lanes = MASK_WIDTH'(8'hFF);
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and RAM port bundle of the load/store unit.
interface lsu_if;
    import lsu_pkg::*;

    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_we;
    logic [1:0]            i_req_size;
    logic                  i_req_unsigned;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic [DATA_WIDTH-1:0] i_req_wdata;
    logic                  o_rsp_valid;
    logic [DATA_WIDTH-1:0] o_rsp_rdata;
    logic                  o_rsp_err;
    logic [ADDR_WIDTH-1:0] o_rd_addr;
    logic                  o_rd_en;
    logic [MASK_WIDTH-1:0] o_rd_mask;
    logic [DATA_WIDTH-1:0] i_rd_data;
    logic [ADDR_WIDTH-1:0] o_wr_addr;
    logic                  o_wr_en;
    logic [MASK_WIDTH-1:0] o_wr_mask;
    logic [DATA_WIDTH-1:0] o_wr_data;

    modport slave (
        input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata, i_rd_data,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_rd_addr, o_rd_en, o_rd_mask, o_wr_addr, o_wr_en, o_wr_mask, o_wr_data
    );

    modport master (
        output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata, i_rd_data,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_rd_addr, o_rd_en, o_rd_mask, o_wr_addr, o_wr_en, o_wr_mask, o_wr_data
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment: per-beat byte mask, write-data shift,
// read-data shift into the merge register, and load-data extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]            off,
    input  size_e                 size,
    input  logic                  beat,
    input  logic                  is_unsigned,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [DATA_WIDTH-1:0] merged,
    output logic [MASK_WIDTH-1:0] mask,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_part,
    output logic [DATA_WIDTH-1:0] ext_data
);

    logic [2*MASK_WIDTH-1:0] mask_wide;
    logic [2*DATA_WIDTH-1:0] wdata_wide;
    logic [6:0]              lane_bits;

    // Shift into a double-width window: low half is beat 0, high half beat 1.
    assign lane_bits  = {1'b0, off, 3'b000};
    assign mask_wide  = {MASK_WIDTH'(0), size_lanes(size)} << off;
    assign wdata_wide = {DATA_WIDTH'(0), wdata} << lane_bits;

    always_comb begin
        mask    = mask_wide[MASK_WIDTH-1:0];
        wr_data = wdata_wide[DATA_WIDTH-1:0];
        rd_part = rd_data >> lane_bits;
        if (beat) begin
            mask    = mask_wide[2*MASK_WIDTH-1:MASK_WIDTH];
            wr_data = wdata_wide[2*DATA_WIDTH-1:DATA_WIDTH];
            rd_part = rd_data << (7'(DATA_WIDTH) - lane_bits);
        end
    end

    always_comb begin
        ext_data = merged;
        case (size)
            SZ_B: ext_data = is_unsigned ? DATA_WIDTH'(merged[7:0])
                                         : {{56{merged[7]}}, merged[7:0]};
            SZ_H: ext_data = is_unsigned ? DATA_WIDTH'(merged[15:0])
                                         : {{48{merged[15]}}, merged[15:0]};
            SZ_W: ext_data = is_unsigned ? DATA_WIDTH'(merged[31:0])
                                         : {{32{merged[31]}}, merged[31:0]};
            default: ext_data = merged;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, byte-masked RAM beats, merged and
// extended load response. LSU_MISALIGN_EN enables split two-beat accesses.
module lsu
    import lsu_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    lsu_if.slave  bus
);

    state_e                state_q, state_d;
    req_t                  req_q;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] merged_q;
    logic                  req_fire;
    logic                  beat;
    logic                  active;
    logic [2:0]            off;
    logic [WORD_WIDTH-1:0] word;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [MASK_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_part;
    logic [DATA_WIDTH-1:0] ext_data;

    assign req_fire  = bus.i_req_valid && (state_q == IDLE);
    assign off       = req_q.addr[2:0];
    assign word      = req_q.addr[ADDR_WIDTH-1:3];
    assign beat      = (state_q == ACC1);
    assign active    = ((state_q == ACC0) || (state_q == ACC1)) && !err_q;
    assign beat_addr = beat ? {word + WORD_WIDTH'(1), 3'b000} : {word, 3'b000};

`ifdef LSU_MISALIGN_EN
    logic cross;
    assign err_d = 1'b0;
    assign cross = (4'(off) + (4'd1 << req_q.size)) > 4'd8;
`else
    // Without split support an offset that is not a multiple of the size is rejected.
    assign err_d = |(bus.i_req_addr[2:0] & 3'((4'd1 << bus.i_req_size) - 4'd1));
`endif

    lsu_align u_align (
        .off         (off),
        .size        (req_q.size),
        .beat        (beat),
        .is_unsigned (req_q.is_unsigned),
        .wdata       (req_q.wdata),
        .rd_data     (bus.i_rd_data),
        .merged      (merged_q),
        .mask        (mask),
        .wr_data     (wr_data),
        .rd_part     (rd_part),
        .ext_data    (ext_data)
    );

    // State, captured request and load merge register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            req_q    <= '0;
            err_q    <= 1'b0;
            merged_q <= '0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                req_q <= '{we:          bus.i_req_we,
                           size:        size_e'(bus.i_req_size),
                           is_unsigned: bus.i_req_unsigned,
                           addr:        bus.i_req_addr,
                           wdata:       bus.i_req_wdata};
                err_q <= err_d;
            end
            if (active && !req_q.we) begin
                merged_q <= beat ? (merged_q | rd_part) : rd_part;
            end
        end
    end

    // Next state and outputs decoded from registered state.
    always_comb begin
        state_d         = state_q;
        bus.o_req_ready = 1'b0;
        bus.o_rsp_valid = 1'b0;
        bus.o_rsp_err   = 1'b0;
        bus.o_rsp_rdata = '0;
        bus.o_rd_en     = 1'b0;
        bus.o_rd_addr   = '0;
        bus.o_rd_mask   = '0;
        bus.o_wr_en     = 1'b0;
        bus.o_wr_addr   = '0;
        bus.o_wr_mask   = '0;
        bus.o_wr_data   = '0;

        if (active) begin
            if (req_q.we) begin
                bus.o_wr_en   = 1'b1;
                bus.o_wr_addr = beat_addr;
                bus.o_wr_mask = mask;
                bus.o_wr_data = wr_data;
            end else begin
                bus.o_rd_en   = 1'b1;
                bus.o_rd_addr = beat_addr;
                bus.o_rd_mask = mask;
            end
        end

        case (state_q)
            IDLE: begin
                bus.o_req_ready = 1'b1;
                if (bus.i_req_valid) state_d = ACC0;
            end
            ACC0: begin
`ifdef LSU_MISALIGN_EN
                state_d = (!err_q && cross) ? ACC1 : RESP;
`else
                state_d = RESP;
`endif
            end
            ACC1: state_d = RESP;
            RESP: begin
                bus.o_rsp_valid = 1'b1;
                bus.o_rsp_err   = err_q;
                bus.o_rsp_rdata = (req_q.we || err_q) ? '0 : ext_data;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: byte-array memory model predicts every cycle of each access;
// a bench-side RAM serves the DUT's read/write ports.
module tb_lsu;
    import lsu_pkg::*;

    typedef struct packed {
        logic        first;
        logic        ready;
        logic        rd_en;
        logic        wr_en;
        logic        rsp_valid;
        logic        rsp_err;
        logic [9:0]  addr;
        logic [7:0]  mask;
        logic [63:0] data;
        logic [63:0] rdata;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst;
    logic ram_clr;
    logic chk_en;
    int   checks;
    int   errors;

    logic [63:0] ram [128];
    logic [7:0]  ref_mem [1024];
    exp_t        exp_q [$];

    logic [9:0]  obs_addr [2];
    logic [7:0]  obs_mask [2];
    logic [63:0] obs_data [2];
    int          obs_beat;
    logic        obs_en_any;
    logic [63:0] obs_rdata;
    logic        obs_err;

    lsu_if bus();

    lsu dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [63:0] lane_expand(input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    // RAM: combinational masked read, write committed on the closing edge.
    assign bus.i_rd_data = bus.o_rd_en ? (ram[bus.o_rd_addr[9:3]] & lane_expand(bus.o_rd_mask)) : 64'd0;

    always @(posedge i_clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 128; i++) ram[i] <= 64'd0;
        end else if (bus.o_wr_en) begin
            for (int b = 0; b < 8; b++)
                if (bus.o_wr_mask[b]) ram[bus.o_wr_addr[9:3]][8*b +: 8] <= bus.o_wr_data[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Per-cycle compare against the model's expectation queue (idle when empty).
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (chk_en) begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                end else begin
                    e = '0;
                    e.ready = 1'b1;
                end
                if (e.first) begin
                    obs_beat   = 0;
                    obs_en_any = 1'b0;
                    for (int i = 0; i < 2; i++) begin
                        obs_addr[i] = '0;
                        obs_mask[i] = '0;
                        obs_data[i] = '0;
                    end
                end
                obs_en_any = obs_en_any | bus.o_rd_en | bus.o_wr_en;
                chk("req_ready", bus.o_req_ready, e.ready);
                chk("rd_en", bus.o_rd_en, e.rd_en);
                chk("wr_en", bus.o_wr_en, e.wr_en);
                chk("rsp_valid", bus.o_rsp_valid, e.rsp_valid);
                if (e.rd_en) begin
                    chk("rd_addr", bus.o_rd_addr, e.addr);
                    chk("rd_mask", bus.o_rd_mask, e.mask);
                    if (obs_beat < 2) begin
                        obs_addr[obs_beat] = bus.o_rd_addr;
                        obs_mask[obs_beat] = bus.o_rd_mask;
                    end
                    obs_beat++;
                end
                if (e.wr_en) begin
                    chk("wr_addr", bus.o_wr_addr, e.addr);
                    chk("wr_mask", bus.o_wr_mask, e.mask);
                    chk("wr_data", bus.o_wr_data & lane_expand(e.mask), e.data & lane_expand(e.mask));
                    if (obs_beat < 2) begin
                        obs_addr[obs_beat] = bus.o_wr_addr;
                        obs_mask[obs_beat] = bus.o_wr_mask;
                        obs_data[obs_beat] = bus.o_wr_data;
                    end
                    obs_beat++;
                end
                if (e.rsp_valid) begin
                    chk("rsp_err", bus.o_rsp_err, e.rsp_err);
                    chk("rsp_rdata", bus.o_rsp_rdata, e.rdata);
                    obs_rdata = bus.o_rsp_rdata;
                    obs_err   = bus.o_rsp_err;
                end
            end
        end
    end

    // Issue one request; the model predicts each cycle from byte-level rules.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [9:0] addr, input logic [63:0] wdata);
        int          n, off, w0, a, b, nb, guard;
        logic        err;
        logic [7:0]  m [2];
        logic [63:0] d [2];
        logic [63:0] val;
        exp_t        e;

        @(posedge i_clk);
        #1;
        bus.i_req_valid    = 1'b1;
        bus.i_req_we       = we;
        bus.i_req_size     = size;
        bus.i_req_unsigned = uns;
        bus.i_req_addr     = addr;
        bus.i_req_wdata    = wdata;
        @(posedge i_clk);
        #1;
        bus.i_req_valid = 1'b0;

        n   = 1 << size;
        off = int'(addr) % 8;
`ifdef LSU_MISALIGN_EN
        err = 1'b0;
`else
        err = (off % n) != 0;
`endif
        w0  = int'(addr) / 8;
        val = '0;
        for (int i = 0; i < 2; i++) begin
            m[i] = '0;
            d[i] = '0;
        end
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                a = (int'(addr) + i) % 1024;
                b = (a / 8 == w0) ? 0 : 1;
                m[b][a % 8] = 1'b1;
                d[b][8*(a % 8) +: 8] = wdata[8*i +: 8];
                if (we) ref_mem[a] = wdata[8*i +: 8];
                else    val[8*i +: 8] = ref_mem[a];
            end
        end
        if (!we && !err && n < 8 && !uns && val[8*n-1]) val = val | ~((64'd1 << (8*n)) - 64'd1);
        if (we || err) val = '0;

        e = '0;
        e.first = 1'b1;
        if (err) begin
            exp_q.push_back(e);
        end else begin
            nb = (m[1] != 8'd0) ? 2 : 1;
            for (int bb = 0; bb < nb; bb++) begin
                e.rd_en = !we;
                e.wr_en = we;
                e.addr  = 10'(((w0 + bb) % 128) * 8);
                e.mask  = m[bb];
                e.data  = d[bb];
                exp_q.push_back(e);
                e.first = 1'b0;
            end
        end
        e = '0;
        e.rsp_valid = 1'b1;
        e.rsp_err   = err;
        e.rdata     = val;
        exp_q.push_back(e);

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge i_clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic init_words();
        do_req(1'b1, 2'd3, 1'b0, 10'h000, 64'h8877665544332211);
        do_req(1'b1, 2'd3, 1'b0, 10'h008, 64'h00FFEEDDCCBBAA99);
    endtask

    // Reset in the middle of a store (second beat of a split store when supported).
    task automatic reset_mid_store();
        logic [63:0] sd;
        sd = 64'h0123456789ABCDEF;
        chk_en = 1'b0;
        @(posedge i_clk);
        #1;
        bus.i_req_valid = 1'b1;
        bus.i_req_we    = 1'b1;
        bus.i_req_size  = 2'd3;
        bus.i_req_wdata = sd;
`ifdef LSU_MISALIGN_EN
        bus.i_req_addr  = 10'h004;
`else
        bus.i_req_addr  = 10'h008;
`endif
        @(posedge i_clk);
        #1;
        bus.i_req_valid = 1'b0;
`ifdef LSU_MISALIGN_EN
        chk("rst_b0_wr_en", bus.o_wr_en, 1'b1);
        chk("rst_b0_mask", bus.o_wr_mask, 8'hF0);
        @(posedge i_clk);
        #1;
        chk("rst_b1_wr_en", bus.o_wr_en, 1'b1);
        chk("rst_b1_mask", bus.o_wr_mask, 8'h0F);
        chk("rst_b1_addr", bus.o_wr_addr, 10'h008);
        for (int i = 0; i < 4; i++) ref_mem[4 + i] = sd[8*i +: 8];
`else
        chk("rst_b0_wr_en", bus.o_wr_en, 1'b1);
        chk("rst_b0_mask", bus.o_wr_mask, 8'hFF);
`endif
        i_rst = 1'b1;
        #1;
        chk("rst_wr_en_drop", bus.o_wr_en, 1'b0);
        chk("rst_ready", bus.o_req_ready, 1'b1);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst_ready", bus.o_req_ready, 1'b1);
        chk("post_rst_rsp_valid", bus.o_rsp_valid, 1'b0);
        chk("post_rst_rdata", bus.o_rsp_rdata, 64'd0);
        chk("rst_word1", ram[1], 64'h00FFEEDDCCBBAA99);
`ifdef LSU_MISALIGN_EN
        chk("rst_word0", ram[0], 64'h89ABCDEF44332211);
`else
        chk("rst_word0", ram[0], 64'h8877665544332211);
`endif
        chk_en = 1'b1;
    endtask

    initial begin
        logic [63:0] w;
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        ram_clr = 1'b1;
        i_rst = 1'b1;
        bus.i_req_valid    = 1'b0;
        bus.i_req_we       = 1'b0;
        bus.i_req_size     = 2'd0;
        bus.i_req_unsigned = 1'b0;
        bus.i_req_addr     = '0;
        bus.i_req_wdata    = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;
        repeat (3) @(posedge i_clk);
        #1;
        ram_clr = 1'b0;
        chk("reset_ready", bus.o_req_ready, 1'b1);
        chk("reset_rsp_valid", bus.o_rsp_valid, 1'b0);
        chk("reset_rd_en", bus.o_rd_en, 1'b0);
        chk("reset_wr_en", bus.o_wr_en, 1'b0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk_en = 1'b1;

        init_words();
        do_req(1'b0, 2'd0, 1'b0, 10'h007, '0);
        chk("lb_mask", obs_mask[0], 8'h80);
        chk("lb_rdata", obs_rdata, 64'hFFFFFFFFFFFFFF88);
        chk("lb_err", obs_err, 1'b0);

`ifdef LSU_MISALIGN_EN
        do_req(1'b0, 2'd3, 1'b0, 10'h005, '0);
        chk("ld_split_addr0", obs_addr[0], 10'h000);
        chk("ld_split_mask0", obs_mask[0], 8'hE0);
        chk("ld_split_addr1", obs_addr[1], 10'h008);
        chk("ld_split_mask1", obs_mask[1], 8'h1F);
        chk("ld_split_rdata", obs_rdata, 64'hDDCCBBAA99887766);
        do_req(1'b1, 2'd1, 1'b0, 10'h3FF, 64'hBEEF);
        chk("sh_wrap_addr0", obs_addr[0], 10'h3F8);
        chk("sh_wrap_mask0", obs_mask[0], 8'h80);
        chk("sh_wrap_byte0", obs_data[0] >> 56, 64'hEF);
        chk("sh_wrap_addr1", obs_addr[1], 10'h000);
        chk("sh_wrap_mask1", obs_mask[1], 8'h01);
        chk("sh_wrap_byte1", obs_data[1] & 64'hFF, 64'hBE);
        do_req(1'b0, 2'd2, 1'b0, 10'h00E, '0);
        do_req(1'b0, 2'd1, 1'b1, 10'h001, '0);
        init_words();
`else
        do_req(1'b0, 2'd3, 1'b0, 10'h005, '0);
        chk("ld_mis_en", obs_en_any, 1'b0);
        chk("ld_mis_err", obs_err, 1'b1);
        chk("ld_mis_rdata", obs_rdata, 64'd0);
        do_req(1'b1, 2'd1, 1'b0, 10'h3FF, 64'hBEEF);
        chk("sh_mis_en", obs_en_any, 1'b0);
        chk("sh_mis_err", obs_err, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 10'h006, '0);
`endif

        do_req(1'b0, 2'd1, 1'b1, 10'h002, '0);
        chk("lhu_rdata", obs_rdata, 64'h0000000000004433);
        do_req(1'b1, 2'd2, 1'b0, 10'h004, 64'h00000000DEADBEEF);
        chk("sw_mask", obs_mask[0], 8'hF0);
        chk("sw_data", obs_data[0], 64'hDEADBEEF00000000);
        do_req(1'b0, 2'd3, 1'b0, 10'h000, '0);
        chk("ld_rdata", obs_rdata, 64'hDEADBEEF44332211);

        do_req(1'b0, 2'd0, 1'b0, 10'h009, '0);
        chk("lb_neg_rdata", obs_rdata, 64'hFFFFFFFFFFFFFFAA);
        do_req(1'b0, 2'd0, 1'b1, 10'h009, '0);
        do_req(1'b0, 2'd2, 1'b0, 10'h008, '0);
        chk("lw_neg_rdata", obs_rdata, 64'hFFFFFFFFCCBBAA99);
        do_req(1'b0, 2'd2, 1'b1, 10'h008, '0);
        do_req(1'b0, 2'd1, 1'b0, 10'h00E, '0);
        chk("lh_pos_rdata", obs_rdata, 64'h00000000000000FF);
        do_req(1'b1, 2'd0, 1'b0, 10'h00F, 64'h7A);
        do_req(1'b0, 2'd3, 1'b0, 10'h008, '0);
        chk("sb_ld_rdata", obs_rdata, 64'h7AFFEEDDCCBBAA99);
        do_req(1'b0, 2'd2, 1'b0, 10'h00C, '0);
        do_req(1'b1, 2'd3, 1'b0, 10'h3F8, 64'hF0E1D2C3B4A59687);
        do_req(1'b0, 2'd3, 1'b0, 10'h3F8, '0);
        do_req(1'b0, 2'd1, 1'b0, 10'h3FE, '0);

        init_words();
        reset_mid_store();
        do_req(1'b0, 2'd3, 1'b0, 10'h008, '0);

        for (int k = 0; k < 128; k++) begin
            for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_mem[8*k + i];
            chk("ram_word", ram[k], w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
